// File: rtl/hps_mem_upload_if.sv
// HPS ioctl upload bus plus the shared byte-wide RAM port used by hps_mem_upload.
// The slave modport is the responder side; master is the HPS/RAM environment side.
interface hps_mem_upload_if #(
    parameter int unsigned AW = 13
);
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_index;
    logic [15:0]   ioctl_din;
    logic          ioctl_wait;
    logic          mem_req;
    logic          mem_gnt;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_q;
    logic [AW:0]   mem_size;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index,
        input  mem_gnt, mem_q, mem_size,
        output ioctl_din, ioctl_wait, mem_req, mem_addr
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index,
        output mem_gnt, mem_q, mem_size,
        input  ioctl_din, ioctl_wait, mem_req, mem_addr
    );
endinterface

// File: rtl/hps_mem_upload.sv
// HPS upload responder: on each read strobe fetches two bytes from a shared
// 8-bit RAM port (req/gnt arbitrated) and returns them as one 16-bit word.
module hps_mem_upload #(
    parameter int unsigned AW     = 13,
    parameter int unsigned RD_LAT = 1,
    parameter logic [7:0]  INDEX  = 8'd1,
    parameter logic [7:0]  FILL   = 8'hFF
) (
    input  logic           clk_sys,
    input  logic           reset_l,
    hps_mem_upload_if.slave bus,
    output logic           busy
);

    localparam int unsigned CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_LO,
        S_HI
    } state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   din_q, din_d;
    logic          wait_q, wait_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;

    logic          trigger;
    logic          abort;
    logic [AW-1:0] base_hi;
    logic          lo_fill;
    logic          hi_fill;
    logic          unused_addr_bits;

    assign trigger = bus.ioctl_rd & bus.ioctl_upload & (bus.ioctl_index == INDEX);
    assign abort   = (state_q != S_IDLE) & ~bus.ioctl_upload;
    assign base_hi = {base_q[AW-1:1], 1'b1};
    // Size compare is one bit wider than the address so mem_size == 2^AW is representable.
    assign lo_fill = ({1'b0, base_q} >= bus.mem_size);
    assign hi_fill = (({1'b0, base_q} + (AW+1)'(1)) >= bus.mem_size);

    assign unused_addr_bits = ^{bus.ioctl_addr >> AW, bus.ioctl_addr[0]};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        din_d   = din_q;
        wait_d  = wait_q;
        req_d   = req_q;
        addr_d  = addr_q;

        if (abort) begin
            state_d = S_IDLE;
            wait_d  = 1'b0;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        base_d  = {bus.ioctl_addr[AW-1:1], 1'b0};
                        phase_d = 1'b0;
                        wait_d  = 1'b1;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    // Re-grant restarts whichever byte was in flight; lo_q survives.
                    if (bus.mem_gnt) begin
                        addr_d  = phase_q ? base_hi : base_q;
                        cnt_d   = '0;
                        state_d = phase_q ? S_HI : S_LO;
                    end
                end
                S_LO, S_HI: begin
                    if (!bus.mem_gnt) begin
                        state_d = S_REQ;
                    end else if (cnt_q != CW'(RD_LAT)) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (state_q == S_LO) begin
                        lo_d    = lo_fill ? FILL : bus.mem_q;
                        addr_d  = base_hi;
                        cnt_d   = '0;
                        phase_d = 1'b1;
                        state_d = S_HI;
                    end else begin
                        din_d   = {(hi_fill ? FILL : bus.mem_q), lo_q};
                        wait_d  = 1'b0;
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            base_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            din_q   <= '0;
            wait_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign busy           = (state_q != S_IDLE);

endmodule
